// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the two pipeline masters, the arbiter and the SoC memory bus.
// The arbiter connects through `master`; the pipeline/slave environment uses `slave`.
interface mem_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] instr_address_in;
  logic                  instr_read_in;
  logic [DATA_WIDTH-1:0] instr_read_value_out;
  logic                  instr_ready_out;

  logic [ADDR_WIDTH-1:0] data_address_in;
  logic                  data_read_in;
  logic                  data_write_in;
  logic [DATA_WIDTH-1:0] data_write_value_in;
  logic [MASK_WIDTH-1:0] data_write_mask_in;
  logic [DATA_WIDTH-1:0] data_read_value_out;
  logic                  data_ready_out;

  logic                  bus_error_out;

  logic [ADDR_WIDTH-1:0] bus_address_out;
  logic                  bus_read_out;
  logic                  bus_write_out;
  logic [DATA_WIDTH-1:0] bus_write_value_out;
  logic [MASK_WIDTH-1:0] bus_write_mask_out;
  logic [DATA_WIDTH-1:0] bus_read_value_in;
  logic                  bus_ready_in;

  modport master (
    input  instr_address_in, instr_read_in,
    output instr_read_value_out, instr_ready_out,
    input  data_address_in, data_read_in, data_write_in,
    input  data_write_value_in, data_write_mask_in,
    output data_read_value_out, data_ready_out,
    output bus_error_out,
    output bus_address_out, bus_read_out, bus_write_out,
    output bus_write_value_out, bus_write_mask_out,
    input  bus_read_value_in, bus_ready_in
  );

  modport slave (
    output instr_address_in, instr_read_in,
    input  instr_read_value_out, instr_ready_out,
    output data_address_in, data_read_in, data_write_in,
    output data_write_value_in, data_write_mask_in,
    input  data_read_value_out, data_ready_out,
    input  bus_error_out,
    input  bus_address_out, bus_read_out, bus_write_out,
    input  bus_write_value_out, bus_write_mask_out,
    output bus_read_value_in, bus_ready_in
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter (fetch + load/store) onto one memory bus, data-first from idle,
// alternating under contention, with a per-transaction watchdog that ends hung accesses.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_bus_arbiter_if.master ports
);
  localparam int          MASK_WIDTH = DATA_WIDTH / 8;
  localparam logic [15:0] WD_LIMIT   = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t                state;
  logic [15:0]           wd_count;
  logic [ADDR_WIDTH-1:0] address_q;
  logic                  read_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] write_value_q;
  logic [MASK_WIDTH-1:0] write_mask_q;

  logic instr_req;
  logic data_req;
  logic granted;
  logic wd_expired;
  logic complete;
  logic timed_out;
  logic load_instr;
  logic load_data;
  logic instr_ready;
  logic data_ready;

  // The completing master is never re-granted directly; the other one wins if it is waiting.
  always_comb begin
    instr_req   = ports.instr_read_in;
    data_req    = ports.data_read_in | ports.data_write_in;
    granted     = (state != IDLE);
    wd_expired  = granted && (wd_count == WD_LIMIT);
    complete    = granted && (ports.bus_ready_in || wd_expired);
    timed_out   = wd_expired && !ports.bus_ready_in;
    load_data   = ((state == IDLE) && data_req) ||
                  ((state == INSTR) && complete && data_req);
    load_instr  = ((state == IDLE) && !data_req && instr_req) ||
                  ((state == DATA) && complete && instr_req);
    instr_ready = (state == INSTR) && complete && instr_req;
    data_ready  = (state == DATA) && complete && data_req;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      wd_count      <= '0;
      address_q     <= '0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      write_value_q <= '0;
      write_mask_q  <= '0;
    end else if (load_data) begin
      state         <= DATA;
      wd_count      <= '0;
      address_q     <= ports.data_address_in;
      read_q        <= ports.data_read_in;
      write_q       <= ports.data_write_in;
      write_value_q <= ports.data_write_value_in;
      write_mask_q  <= ports.data_write_mask_in;
    end else if (load_instr) begin
      state         <= INSTR;
      wd_count      <= '0;
      address_q     <= ports.instr_address_in;
      read_q        <= 1'b1;
      write_q       <= 1'b0;
      write_value_q <= '0;
      write_mask_q  <= '0;
    end else if (complete) begin
      state    <= IDLE;
      wd_count <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
    end else if (granted) begin
      wd_count <= wd_count + 16'd1;
    end
  end

  // Read data is zeroed on a timeout so a stalled load never consumes stale bus values.
  assign ports.instr_read_value_out = (granted && !timed_out) ? ports.bus_read_value_in : '0;
  assign ports.data_read_value_out  = (granted && !timed_out) ? ports.bus_read_value_in : '0;
  assign ports.instr_ready_out      = instr_ready;
  assign ports.data_ready_out       = data_ready;
  assign ports.bus_error_out        = timed_out && (instr_ready || data_ready);

  assign ports.bus_address_out     = address_q;
  assign ports.bus_read_out        = read_q;
  assign ports.bus_write_out       = write_q;
  assign ports.bus_write_value_out = write_value_q;
  assign ports.bus_write_mask_out  = write_mask_q;
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter that merges the fetch-stage instruction port and the memory-stage data port onto the single SoC memory bus. It produces the `instr_ready_out` / `data_ready_out` signals consumed by the pipeline hazard unit, so its handshake timing directly determines fetch and memory-stage stalls. Requests are registered at grant, and at most one bus transaction is outstanding. A per-transaction watchdog terminates hung slave accesses with an error.

## Interface
- `ADDR_WIDTH`, default 32: byte address width.
- `DATA_WIDTH`, default 32: data width; the write mask is `DATA_WIDTH/8` bits wide.
- `TIMEOUT`, default 255: maximum number of bus-active cycles before forced termination; legal range 1..65535.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `instr_address_in`  in  ADDR_WIDTH  fetch address.
- `instr_read_in`  in  1  fetch request.
- `instr_read_value_out`  out  DATA_WIDTH  fetch data, valid while `instr_ready_out` is high.
- `instr_ready_out`  out  1  one-cycle fetch completion.
- `data_address_in`  in  ADDR_WIDTH  load/store address.
- `data_read_in`  in  1  load request.
- `data_write_in`  in  1  store request; must be mutually exclusive with `data_read_in`.
- `data_write_value_in`  in  DATA_WIDTH  store data.
- `data_write_mask_in`  in  DATA_WIDTH/8  store byte enables.
- `data_read_value_out`  out  DATA_WIDTH  load data, valid while `data_ready_out` is high.
- `data_ready_out`  out  1  one-cycle load/store completion.
- `bus_error_out`  out  1  high with either ready output when that completion was a timeout.
- `bus_address_out`  out  ADDR_WIDTH  registered address.
- `bus_read_out`, `bus_write_out`  out  1 each  registered strobes.
- `bus_write_value_out`  out  DATA_WIDTH  registered store data.
- `bus_write_mask_out`  out  DATA_WIDTH/8  registered byte enables.
- `bus_read_value_in`  in  DATA_WIDTH  slave read data.
- `bus_ready_in`  in  1  slave completion; may arrive in any cycle at or after the first strobe cycle.

## Operation
- FSM states:
  - `IDLE`: no grant, bus strobes low.
  - `INSTR`: fetch owns the bus.
  - `DATA`: data port owns the bus.
- Priority from `IDLE`: data beats instruction. When both ports request in the same cycle, `DATA` is granted.
- Grant latching:
  - On entry to `INSTR` or `DATA`, the granted master's address, strobes, write value and mask are latched into the `bus_*_out` registers.
  - Instruction grants drive `bus_write_out=0` and mask 0.
  - The registered values stay stable until the transaction completes.
- Completion:
  - Completion occurs on the cycle `bus_ready_in=1` in a granted state, or on the cycle the watchdog expires.
  - The owner's ready output is asserted combinationally in that cycle, but only if the owner is still requesting.
  - A master that dropped its request (for example, fetch after a flush) still has its transaction finished on the bus, and the completion is silently discarded.
- Next state at completion, with no bubble:
  - Go to the other master's state if it is requesting in that cycle.
  - Otherwise go to `IDLE`.
  - The completing master is never re-granted directly, which gives round-robin fairness under contention.
- Read data:
  - `bus_read_value_in` is routed to both `*_read_value_out` ports.
  - Each port is only meaningful under its own ready.
  - On a timeout completion, both read value outputs are forced to 0.
- Watchdog:
  - A 16-bit counter clears on each grant and increments each granted cycle without `bus_ready_in`.
  - When count equals `TIMEOUT-1` and `bus_ready_in=0`, the transaction completes with `bus_error_out=1`.
  - The bus strobes drop on the following edge as with a normal completion.
  - A `bus_ready_in` arriving in the expiry cycle wins, giving a normal completion with error 0.
- `bus_ready_in` in `IDLE` is ignored.

## Timing
- Reset values: state `IDLE`. All of the following are 0:
  - `bus_address_out`, `bus_read_out`, `bus_write_out`, `bus_write_value_out`, `bus_write_mask_out`
  - the watchdog counter
  - `instr_ready_out`, `data_ready_out`, `bus_error_out`
- Reset mid-transaction: on assertion, all outputs return to their reset values immediately, and no ready output is produced.
- Arbitration latency:
  - A request first seen high in cycle N, from `IDLE`, produces bus strobes in cycle N+1.
  - Best-case master latency is 2 cycles, when the slave is ready in the first strobe cycle.
- Back-to-back: the next master's strobes appear in the cycle after the previous completion. There is no dead cycle between transactions.
- Masters hold their request inputs stable until their ready output. The arbiter samples their address and data only at grant.

## Test plan
- Single fetch:
  - Stimulus: `instr_read_in=1`, address 0x100, slave ready in the first strobe cycle, read data 0x00000013.
  - Required: strobes in cycle N+1; `instr_ready_out=1` in N+1 with value 0x13; state `IDLE` in N+2.
- Simultaneous requests:
  - Stimulus: fetch at 0x200 and store to 0x8000 (value 0xDEADBEEF, mask 0xF) in the same cycle; slave ready after 3 cycles each.
  - Required: store is issued first, then the fetch strobes in the cycle after `data_ready_out`; no idle gap.
- Fairness:
  - Stimulus: both ports continuously requesting for 6 transactions.
  - Required: grant order D,I,D,I,D,I.
- Abandoned fetch:
  - Stimulus: fetch granted, `instr_read_in` drops before `bus_ready_in`.
  - Required: bus transaction completes; `instr_ready_out` stays 0.
- Timeout:
  - Stimulus: `TIMEOUT=4`, load with slave never ready.
  - Required: in the 4th strobe cycle, `data_ready_out=1`, `bus_error_out=1`, `data_read_value_out=0`; strobes low the next cycle.
  - Repeat with `bus_ready_in` in exactly that expiry cycle. Required: error 0.
- Reset mid-transaction:
  - Stimulus: assert `reset_n=0` during a store.
  - Required: all outputs 0 asynchronously; after release, state `IDLE` and a new fetch proceeds normally.
